ex_mem_stage_reg: RTL and testbench

- Parametrised EX->MEM pipeline register with a valid/ready handshake, synchronous flush and an optional 2-entry skid buffer.
- Sits between the execute stage and the memory stage of the RV32IM pipeline, where a plain unconditional register stood before.
- Lets MEM apply back-pressure (for example, multi-cycle data memory or a divider hand-off) without losing EX results.
- Guarantees that bubbles never carry live memory or writeback control.

---
 rtl/pipe_pkg.sv | 39 +++
 rtl/skid_buffer.sv | 128 ++++++++++++
 rtl/ex_mem_stage_reg.sv | 85 ++++++++
 tb/tb_ex_mem_stage_reg.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared EX->MEM pipeline types: load/store encodings, payload bundle,
// skid FSM states and the bubble value of the payload.
package pipe_pkg;

   localparam int P_XLEN = 32;

   localparam logic [2:0] LOAD_NONE = 3'b111;

   localparam logic [1:0] STORE_B = 2'b00;
   localparam logic [1:0] STORE_H = 2'b01;
   localparam logic [1:0] STORE_W = 2'b10;

   typedef enum logic [1:0] {
      SB_EMPTY = 2'd0,
      SB_ONE   = 2'd1,
      SB_FULL  = 2'd2
   } skid_state_t;

   typedef struct packed {
      logic [P_XLEN-1:0] result;
      logic [P_XLEN-1:0] op2;
      logic              write;
      logic [2:0]        load_type;
      logic [1:0]        store_type;
      logic              wb_load;
   } ex_mem_payload_t;

   // A bubble carries no memory access and no load writeback.
   function automatic ex_mem_payload_t bubble_payload(
      input logic [2:0] load_none
   );
      ex_mem_payload_t p;
      p           = '0;
      p.load_type = load_none;
      p.store_type = STORE_B;
      return p;
   endfunction

endpackage

// File: rtl/skid_buffer.sv
// Valid/ready register slice: 2-entry FIFO skid with registered in_ready,
// or a single register with combinational in_ready.
module skid_buffer
   import pipe_pkg::*;
#(
   parameter int W       = 8,
   parameter bit SKID_EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   if (SKID_EN) begin : g_skid

      skid_state_t  state;
      logic         rdy;
      logic         ov;
      logic [W-1:0] dout;
      logic [W-1:0] skid;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state <= SB_EMPTY;
            rdy   <= 1'b1;
            ov    <= 1'b0;
            dout  <= '0;
            skid  <= '0;
         end else if (flush) begin
            state <= SB_EMPTY;
            rdy   <= 1'b1;
            ov    <= 1'b0;
         end else begin
            unique case (state)
               SB_EMPTY: begin
                  if (in_valid) begin
                     dout  <= in_data;
                     ov    <= 1'b1;
                     state <= SB_ONE;
                  end
               end
               SB_ONE: begin
                  unique case (1'b1)
                     in_valid & out_ready: begin
                        dout <= in_data;
                     end
                     in_valid & ~out_ready: begin
                        skid  <= in_data;
                        rdy   <= 1'b0;
                        state <= SB_FULL;
                     end
                     ~in_valid & out_ready: begin
                        ov    <= 1'b0;
                        state <= SB_EMPTY;
                     end
                     default: begin
                     end
                  endcase
               end
               SB_FULL: begin
                  // Drain strictly in order: skid entry moves to output.
                  if (out_ready) begin
                     dout  <= skid;
                     rdy   <= 1'b1;
                     state <= SB_ONE;
                  end
               end
               default: begin
                  state <= SB_EMPTY;
                  rdy   <= 1'b1;
                  ov    <= 1'b0;
               end
            endcase
         end
      end

      assign in_ready  = rdy;
      assign out_valid = ov;
      assign out_data  = dout;

      a_full_not_ready: assert property (
         @(posedge clk) disable iff (!rst_n)
         (state == SB_FULL) |-> !in_ready
      );

      a_no_accept_full: assert property (
         @(posedge clk) disable iff (!rst_n)
         !((state == SB_FULL) && in_valid && in_ready)
      );

      a_ready_matches: assert property (
         @(posedge clk) disable iff (!rst_n)
         rdy == (state != SB_FULL)
      );

   end else begin : g_plain

      logic         ov;
      logic [W-1:0] dout;

      assign in_ready = out_ready | ~ov;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ov   <= 1'b0;
            dout <= '0;
         end else if (flush) begin
            ov <= 1'b0;
         end else if (in_valid && in_ready) begin
            dout <= in_data;
            ov   <= 1'b1;
         end else if (out_ready) begin
            ov <= 1'b0;
         end
      end

      assign out_valid = ov;
      assign out_data  = dout;

   end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline register with handshake, flush, bubble masking
// and a saturating back-pressure counter.
module ex_mem_stage_reg #(
   parameter int         XLEN      = 32,
   parameter bit         SKID_EN   = 1'b1,
   parameter logic [2:0] LOAD_NONE = 3'b111,
   parameter int         CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  ex_result,
   input  logic [XLEN-1:0]  ex_op2_selected,
   input  logic             ex_memory_write,
   input  logic [2:0]       ex_memory_load_type,
   input  logic [1:0]       ex_memory_store_type,
   input  logic             ex_wb_load,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  mem_result,
   output logic [XLEN-1:0]  mem_op2_selected,
   output logic             mem_memory_write,
   output logic [2:0]       mem_memory_load_type,
   output logic [1:0]       mem_memory_store_type,
   output logic             mem_wb_load,
   output logic [CNT_W-1:0] stall_cycles
);

   import pipe_pkg::*;

   localparam int W = $bits(ex_mem_payload_t);

   ex_mem_payload_t in_pl;
   ex_mem_payload_t sb_pl;
   ex_mem_payload_t out_pl;
   logic            sb_valid;

   always_comb begin
      in_pl            = '0;
      in_pl.result     = ex_result;
      in_pl.op2        = ex_op2_selected;
      in_pl.write      = ex_memory_write;
      in_pl.load_type  = ex_memory_load_type;
      in_pl.store_type = ex_memory_store_type;
      in_pl.wb_load    = ex_wb_load;
   end

   skid_buffer #(
      .W       (W),
      .SKID_EN (SKID_EN)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_pl),
      .out_valid (sb_valid),
      .out_ready (out_ready),
      .out_data  (sb_pl)
   );

   // Stale register contents never leak: empty slot reads as a bubble.
   assign out_pl = sb_valid ? sb_pl : bubble_payload(LOAD_NONE);

   assign out_valid             = sb_valid;
   assign mem_result            = out_pl.result;
   assign mem_op2_selected      = out_pl.op2;
   assign mem_memory_write      = out_pl.write;
   assign mem_memory_load_type  = out_pl.load_type;
   assign mem_memory_store_type = out_pl.store_type;
   assign mem_wb_load           = out_pl.wb_load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (sb_valid && !out_ready &&
                   stall_cycles != {CNT_W{1'b1}}) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Bench: skid (CNT_W=4) and plain instances share stimulus and are
// checked every cycle against a queue model plus literal expectations.
module tb_ex_mem_stage_reg;

   typedef logic [70:0] pl_t;

   localparam pl_t BUB = {32'h0, 32'h0, 1'b0, 3'b111, 2'b00, 1'b0};

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] ex_result;
   logic [31:0] ex_op2_selected;
   logic        ex_memory_write;
   logic [2:0]  ex_memory_load_type;
   logic [1:0]  ex_memory_store_type;
   logic        ex_wb_load;

   logic        a_in_ready, a_out_valid, a_write, a_wb;
   logic [31:0] a_res, a_op2;
   logic [2:0]  a_ld;
   logic [1:0]  a_st;
   logic [3:0]  a_stall;

   logic        b_in_ready, b_out_valid, b_write, b_wb;
   logic [31:0] b_res, b_op2;
   logic [2:0]  b_ld;
   logic [1:0]  b_st;
   logic [15:0] b_stall;

   int checks   = 0;
   int failures = 0;

   pl_t qa[$];
   pl_t qb[$];
   int  ca = 0;
   int  cb = 0;

   ex_mem_stage_reg #(
      .XLEN(32), .SKID_EN(1'b1), .LOAD_NONE(3'b111), .CNT_W(4)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready),
      .ex_result(ex_result), .ex_op2_selected(ex_op2_selected),
      .ex_memory_write(ex_memory_write),
      .ex_memory_load_type(ex_memory_load_type),
      .ex_memory_store_type(ex_memory_store_type),
      .ex_wb_load(ex_wb_load),
      .out_valid(a_out_valid), .out_ready(out_ready),
      .mem_result(a_res), .mem_op2_selected(a_op2),
      .mem_memory_write(a_write), .mem_memory_load_type(a_ld),
      .mem_memory_store_type(a_st), .mem_wb_load(a_wb),
      .stall_cycles(a_stall)
   );

   ex_mem_stage_reg #(
      .XLEN(32), .SKID_EN(1'b0), .LOAD_NONE(3'b111), .CNT_W(16)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready),
      .ex_result(ex_result), .ex_op2_selected(ex_op2_selected),
      .ex_memory_write(ex_memory_write),
      .ex_memory_load_type(ex_memory_load_type),
      .ex_memory_store_type(ex_memory_store_type),
      .ex_wb_load(ex_wb_load),
      .out_valid(b_out_valid), .out_ready(out_ready),
      .mem_result(b_res), .mem_op2_selected(b_op2),
      .mem_memory_write(b_write), .mem_memory_load_type(b_ld),
      .mem_memory_store_type(b_st), .mem_wb_load(b_wb),
      .stall_cycles(b_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic pl_t mk(input logic [31:0] v);
      return {v, ~v, v[0], v[3:1], v[5:4], v[6]};
   endfunction

   function automatic pl_t cur_in();
      return {ex_result, ex_op2_selected, ex_memory_write,
              ex_memory_load_type, ex_memory_store_type, ex_wb_load};
   endfunction

   task automatic chk(input string nm, input pl_t act, input pl_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [31:0] v, input logic vld);
      ex_result            = v;
      ex_op2_selected      = ~v;
      ex_memory_write      = v[0];
      ex_memory_load_type  = v[3:1];
      ex_memory_store_type = v[5:4];
      ex_wb_load           = v[6];
      in_valid             = vld;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: each instance is a FIFO of capacity 2 (skid) or 1 (plain).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qa.delete();
         qb.delete();
         ca = 0;
         cb = 0;
      end else begin
         bit ra, rb;
         pl_t c;
         c  = cur_in();
         ra = qa.size() < 2;
         rb = out_ready || qb.size() == 0;
         if (qa.size() > 0 && !out_ready && ca < 15) ca++;
         if (qb.size() > 0 && !out_ready && cb < 65535) cb++;
         if (qa.size() > 0 && out_ready) void'(qa.pop_front());
         if (qb.size() > 0 && out_ready) void'(qb.pop_front());
         if (flush) begin
            qa.delete();
            qb.delete();
         end else begin
            if (in_valid && ra) qa.push_back(c);
            if (in_valid && rb) qb.push_back(c);
         end
      end
   end

   always @(negedge clk) begin
      chk("a_valid", 71'(a_out_valid), 71'(qa.size() > 0));
      chk("a_ready", 71'(a_in_ready), 71'(qa.size() < 2));
      chk("a_payload", {a_res, a_op2, a_write, a_ld, a_st, a_wb},
          qa.size() > 0 ? qa[0] : BUB);
      chk("a_stall", 71'(a_stall), 71'(ca));
      chk("b_valid", 71'(b_out_valid), 71'(qb.size() > 0));
      chk("b_ready", 71'(b_in_ready),
          71'(out_ready || qb.size() == 0));
      chk("b_payload", {b_res, b_op2, b_write, b_ld, b_st, b_wb},
          qb.size() > 0 ? qb[0] : BUB);
      chk("b_stall", 71'(b_stall), 71'(cb));
   end

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive(32'h0, 1'b0);
      tick();
      chk("rst_valid", 71'(a_out_valid), 71'(0));
      chk("rst_ld", 71'(a_ld), 71'(3'b111));
      chk("rst_ready", 71'(a_in_ready), 71'(1));
      chk("rst_stall", 71'(a_stall), 71'(0));
      tick();
      rst_n = 1'b1;
      tick();

      // Streaming: one result per cycle, one cycle latency.
      out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         drive(32'(i), 1'b1);
         tick();
         chk("stream_a", 71'(a_res), 71'(i));
         chk("stream_b", 71'(b_res), 71'(i));
         chk("stream_rdy", 71'(a_in_ready), 71'(1));
      end
      drive(32'h0, 1'b0);
      tick();

      // Back-pressure: A, B fill the skid, C waits.
      out_ready = 1'b0;
      drive(32'h10, 1'b1);
      tick();
      drive(32'h20, 1'b1);
      tick();
      chk("bp_full_rdy", 71'(a_in_ready), 71'(0));
      drive(32'h30, 1'b1);
      tick();
      tick();
      chk("bp_stall", 71'(a_stall), 71'(3));
      chk("bp_first", 71'(a_res), 71'(32'h10));
      out_ready = 1'b1;
      tick();
      chk("bp_second", 71'(a_res), 71'(32'h20));
      tick();
      chk("bp_third", 71'(a_res), 71'(32'h30));
      drive(32'h0, 1'b0);
      tick();
      chk("bp_drained", 71'(a_out_valid), 71'(0));

      // Flush in FULL drops the concurrent input D.
      out_ready = 1'b0;
      drive(32'h41, 1'b1);
      tick();
      drive(32'h42, 1'b1);
      tick();
      drive(32'h40, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(32'h0, 1'b0);
      chk("fl_valid", 71'(a_out_valid), 71'(0));
      chk("fl_write", 71'(a_write), 71'(0));
      chk("fl_ld", 71'(a_ld), 71'(3'b111));
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("fl_no_d", 71'(a_out_valid), 71'(0));
      end

      // Asynchronous reset while FULL.
      out_ready = 1'b0;
      drive(32'h61, 1'b1);
      tick();
      drive(32'h62, 1'b1);
      tick();
      chk("pre_rst_full", 71'(a_in_ready), 71'(0));
      drive(32'h0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 71'(a_out_valid), 71'(0));
      chk("mid_rst_ld", 71'(a_ld), 71'(3'b111));
      chk("mid_rst_ready", 71'(a_in_ready), 71'(1));
      chk("mid_rst_stall", 71'(a_stall), 71'(0));
      tick();
      rst_n = 1'b1;
      tick();

      // Plain-register stall, payload stability, counter saturation.
      out_ready = 1'b1;
      drive(32'h55, 1'b1);
      tick();
      drive(32'h0, 1'b0);
      out_ready = 1'b0;
      #1;
      chk("b_stall_rdy", 71'(b_in_ready), 71'(0));
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("b_hold", {b_res, b_op2, b_write, b_ld, b_st, b_wb},
             mk(32'h55));
      end
      chk("a_sat", 71'(a_stall), 71'(15));
      chk("b_cnt20", 71'(b_stall), 71'(20));
      tick();
      chk("a_sat_hold", 71'(a_stall), 71'(15));
      out_ready = 1'b1;
      tick();
      chk("b_released", 71'(b_out_valid), 71'(0));
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
